// File: rtl/vp_instr_sequencer_if.sv
// vp_instr_sequencer_if
//   Groups the instruction-memory read port and the issue handshake of the
//   vp_instr_sequencer.
//   master (sequencer side): drives imem_addr, op_code, operand, op_valid;
//                            receives imem_data, op_ready.
//   slave  (memory/datapath side): the mirror image.
interface vp_instr_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [2:0]         op_code;
  logic [INSTR_W-4:0] operand;
  logic               op_valid;
  logic               op_ready;

  modport master (
    output imem_addr, op_code, operand, op_valid,
    input  imem_data, op_ready
  );

  modport slave (
    input  imem_addr, op_code, operand, op_valid,
    output imem_data, op_ready
  );
endinterface

// File: rtl/vp_instr_sequencer.sv
// vp_instr_sequencer
//   Fetches instruction words from a synchronous (1-cycle latency) instruction
//   memory and issues their op_code/operand to the datapath over a valid/ready
//   handshake. NOP words are skipped, HALT or the last memory word ends the
//   program.
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     start        : one-cycle pulse, runs the program from address 0
//     abort        : returns to IDLE from any state, highest priority
//     bus (master) : imem_addr/imem_data read port, op_code/operand/op_valid/
//                    op_ready issue handshake
//     busy         : high in FETCH, DECODE, ISSUE
//     done         : high in DONE
//     instr_count  : instructions accepted since the last start
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// FETCH  | memory samples imem_addr = pc
// DECODE | imem_data valid; skip NOP, stop on HALT, else latch for issue
// ISSUE  | op_valid high, holding op_code/operand until op_ready
// DONE   | program finished; start re-runs from address 0
module vp_instr_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  vp_instr_sequencer_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_DONE
  } state_t;

  localparam logic [2:0]        OP_NOP  = 3'b010;
  localparam logic [2:0]        OP_HALT = 3'b011;
  localparam logic [ADDR_W-1:0] PC_LAST = '1;
  localparam logic [ADDR_W-1:0] PC_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [2:0]         op_code_r;
  logic [INSTR_W-4:0] operand_r;
  logic               op_valid_r;
  logic [2:0]         dec_op;

  assign dec_op        = bus.imem_data[INSTR_W-1:INSTR_W-3];
  assign bus.imem_addr = pc;
  assign bus.op_code   = op_code_r;
  assign bus.operand   = operand_r;
  assign bus.op_valid  = op_valid_r;
  assign busy          = (state == S_FETCH) || (state == S_DECODE) || (state == S_ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      op_code_r   <= OP_NOP;
      operand_r   <= '0;
      op_valid_r  <= 1'b0;
      done        <= 1'b0;
      instr_count <= '0;
    end else if (abort) begin
      // pc and instr_count are left as they were for post-mortem inspection
      state      <= S_IDLE;
      op_valid_r <= 1'b0;
      op_code_r  <= OP_NOP;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc          <= '0;
            instr_count <= '0;
            done        <= 1'b0;
            state       <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (dec_op == OP_HALT) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (dec_op == OP_NOP) begin
            if (pc == PC_LAST) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              pc    <= pc + PC_ONE;
              state <= S_FETCH;
            end
          end else begin
            op_code_r  <= dec_op;
            operand_r  <= bus.imem_data[INSTR_W-4:0];
            op_valid_r <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.op_ready) begin
            instr_count <= instr_count + CNT_ONE;
            op_valid_r  <= 1'b0;
            op_code_r   <= OP_NOP;
            // last word ends the program instead of wrapping pc to 0
            if (pc == PC_LAST) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              pc    <= pc + PC_ONE;
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vp_instr_sequencer.sv
// tb_vp_instr_sequencer
//   Scoreboard bench: expected issue words are derived from the loaded program
//   image and compared against every cycle the DUT holds op_valid. A second
//   instance with ADDR_W=2 exercises the end-of-memory stop.
module tb_vp_instr_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic start2 = 1'b0;
  logic abort2 = 1'b0;

  always #5 clk = ~clk;

  vp_instr_sequencer_if #(.ADDR_W(8), .INSTR_W(16)) bus ();
  vp_instr_sequencer_if #(.ADDR_W(2), .INSTR_W(16)) bus2 ();

  logic       busy, done;
  logic [8:0] instr_count;
  logic       busy2, done2;
  logic [2:0] instr_count2;

  vp_instr_sequencer #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus),
    .busy(busy), .done(done), .instr_count(instr_count)
  );

  vp_instr_sequencer #(.ADDR_W(2), .INSTR_W(16)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .bus(bus2),
    .busy(busy2), .done(done2), .instr_count(instr_count2)
  );

  logic [15:0] mem  [256];
  logic [15:0] mem2 [4];

  always @(posedge clk) bus.imem_data  <= mem[bus.imem_addr];
  always @(posedge clk) bus2.imem_data <= mem2[bus2.imem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // scoreboard and observation queues
  logic [15:0] exp_q  [$];
  logic [15:0] exp2_q [$];
  int rise_q [$];
  int acc_q  [$];
  int len_q  [$];
  int run_len = 0;
  int n_issue2 = 0;

  // op_ready driver: withholds ready for the first stall_req valid cycles of a run
  int stall_req = 0;
  initial begin
    int stalled;
    stalled = 0;
    bus.op_ready = 1'b1;
    bus2.op_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!busy) stalled = 0;
      if (bus.op_valid && stalled < stall_req) begin
        bus.op_ready = 1'b0;
        stalled++;
      end else begin
        bus.op_ready = 1'b1;
      end
    end
  end

  // monitor for the main instance
  initial forever begin
    @(negedge clk);
    if (bus.op_valid) begin
      if (exp_q.size() == 0) chk("unexpected_issue", 32'(1), 32'(0));
      else chk("issued_word", 32'({bus.op_code, bus.operand}), 32'(exp_q[0]));
      if (run_len == 0) rise_q.push_back(cyc);
      run_len++;
      if (bus.op_ready && !abort && !rst) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        acc_q.push_back(cyc);
      end
    end else if (run_len != 0) begin
      len_q.push_back(run_len);
      run_len = 0;
    end
  end

  // monitor for the ADDR_W=2 instance
  initial forever begin
    @(negedge clk);
    if (bus2.op_valid && bus2.op_ready) begin
      n_issue2++;
      if (exp2_q.size() == 0) chk("unexpected_issue2", 32'(1), 32'(0));
      else begin
        chk("issued_word2", 32'({bus2.op_code, bus2.operand}), 32'(exp2_q[0]));
        void'(exp2_q.pop_front());
      end
    end
  end

  task automatic fill_halt();
    for (int a = 0; a < 256; a++) mem[a] = {3'b011, 13'h0};
  endtask

  task automatic prog_basic();
    fill_halt();
    mem[0] = {3'b100, 13'h0a1};
    mem[1] = {3'b101, 13'h1b2};
    mem[2] = {3'b000, 13'h0c3};
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int a = 0; a < 256; a++) begin
      if (mem[a][15:13] == 3'b011) break;
      if (mem[a][15:13] != 3'b010) exp_q.push_back(mem[a]);
    end
  endtask

  task automatic clear_obs();
    rise_q.delete();
    acc_q.delete();
    len_q.delete();
  endtask

  int start_cyc = 0;
  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int i;
    i = 0;
    while (!done && i < max) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk(tag, 32'(done), 32'(1));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int i;
    i = 0;
    while (!bus.op_valid && i < max) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk(tag, 32'(bus.op_valid), 32'(1));
  endtask

  initial begin
    fill_halt();
    for (int a = 0; a < 4; a++) mem2[a] = {3'b001, 13'(16 + a)};

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_code", 32'(bus.op_code), 32'(3'b010));
    chk("rst_operand", 32'(bus.operand), 32'(0));
    chk("rst_op_valid", 32'(bus.op_valid), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_count", 32'(instr_count), 32'(0));
    chk("rst_addr", 32'(bus.imem_addr), 32'(0));
    rst = 1'b0;

    // basic program, always ready
    prog_basic();
    build_exp();
    clear_obs();
    stall_req = 0;
    pulse_start();
    wait_done("t1_done", 100);
    chk("t1_count", 32'(instr_count), 32'(3));
    chk("t1_busy", 32'(busy), 32'(0));
    chk("t1_pc_at_halt", 32'(bus.imem_addr), 32'(3));
    chk("t1_sb_empty", 32'(exp_q.size()), 32'(0));
    chk("t1_runs", 32'(len_q.size()), 32'(3));
    if (rise_q.size() > 0) chk("t1_latency", 32'(rise_q[0] - start_cyc), 32'(3));
    for (int i = 0; i < len_q.size(); i++) chk("t1_run_len", 32'(len_q[i]), 32'(1));
    for (int i = 0; i + 1 < rise_q.size() && i < acc_q.size(); i++)
      chk("t1_gap", 32'(rise_q[i+1] - acc_q[i]), 32'(3));

    // first op stalled for 4 cycles; a start during busy is ignored
    build_exp();
    clear_obs();
    stall_req = 4;
    pulse_start();
    wait_valid("t2_valid", 20);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t2_done", 100);
    chk("t2_count", 32'(instr_count), 32'(3));
    chk("t2_sb_empty", 32'(exp_q.size()), 32'(0));
    chk("t2_runs", 32'(len_q.size()), 32'(3));
    if (len_q.size() > 0) chk("t2_stall_len", 32'(len_q[0]), 32'(5));
    if (rise_q.size() > 1 && acc_q.size() > 0)
      chk("t2_gap", 32'(rise_q[1] - acc_q[0]), 32'(3));
    stall_req = 0;

    // NOP skipping
    fill_halt();
    mem[0] = {3'b010, 13'h011};
    mem[1] = {3'b010, 13'h022};
    mem[2] = {3'b111, 13'h1ee};
    build_exp();
    clear_obs();
    pulse_start();
    wait_done("t3_done", 100);
    chk("t3_count", 32'(instr_count), 32'(1));
    chk("t3_sb_empty", 32'(exp_q.size()), 32'(0));
    chk("t3_runs", 32'(len_q.size()), 32'(1));
    if (rise_q.size() > 0) chk("t3_latency", 32'(rise_q[0] - start_cyc), 32'(7));

    // end of memory on a 4-word instance, no HALT
    exp2_q.delete();
    for (int a = 0; a < 4; a++) exp2_q.push_back(mem2[a]);
    n_issue2 = 0;
    @(posedge clk);
    #1;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    begin
      int i;
      i = 0;
      while (!done2 && i < 100) begin
        @(posedge clk);
        #1;
        i++;
      end
    end
    chk("t4_done", 32'(done2), 32'(1));
    repeat (5) @(posedge clk);
    #1;
    chk("t4_count", 32'(instr_count2), 32'(4));
    chk("t4_issues", 32'(n_issue2), 32'(4));
    chk("t4_no_wrap", 32'(bus2.imem_addr), 32'(3));
    chk("t4_done_hold", 32'(done2), 32'(1));
    chk("t4_sb_empty", 32'(exp2_q.size()), 32'(0));

    // abort coincident with op_ready on the second issue
    prog_basic();
    build_exp();
    clear_obs();
    pulse_start();
    begin
      int i;
      i = 0;
      while (!(bus.op_valid && bus.op_code == 3'b101) && i < 50) begin
        @(posedge clk);
        #1;
        i++;
      end
    end
    chk("t5_second_issue", 32'({bus.op_valid, bus.op_ready, bus.op_code}), 32'({2'b11, 3'b101}));
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("t5_valid", 32'(bus.op_valid), 32'(0));
    chk("t5_op_code", 32'(bus.op_code), 32'(3'b010));
    chk("t5_busy", 32'(busy), 32'(0));
    chk("t5_done", 32'(done), 32'(0));
    chk("t5_count", 32'(instr_count), 32'(1));
    chk("t5_pc_hold", 32'(bus.imem_addr), 32'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("t5_idle_valid", 32'(bus.op_valid), 32'(0));
    build_exp();
    clear_obs();
    pulse_start();
    chk("t5_restart_addr", 32'(bus.imem_addr), 32'(0));
    chk("t5_restart_count", 32'(instr_count), 32'(0));
    wait_done("t5_done2", 100);
    chk("t5_count2", 32'(instr_count), 32'(3));
    chk("t5_sb_empty", 32'(exp_q.size()), 32'(0));

    // reset during ISSUE
    build_exp();
    clear_obs();
    stall_req = 20;
    pulse_start();
    wait_valid("t6_valid", 20);
    rst = 1'b1;
    #1;
    chk("t6_op_valid", 32'(bus.op_valid), 32'(0));
    chk("t6_op_code", 32'(bus.op_code), 32'(3'b010));
    chk("t6_operand", 32'(bus.operand), 32'(0));
    chk("t6_count", 32'(instr_count), 32'(0));
    chk("t6_addr", 32'(bus.imem_addr), 32'(0));
    chk("t6_busy", 32'(busy), 32'(0));
    chk("t6_done", 32'(done), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall_req = 0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("t6_stays_idle", 32'({busy, bus.op_valid}), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vp_instr_sequencer.md
Name: vp_instr_sequencer

Overview:
- Issue-side counterpart of the vector processor control unit. Fetches instruction words from a synchronous instruction memory and drives the 3-bit op_code that the control unit decodes into register and memory write enables and mux selects.
- Also presents the instruction operand field and a valid/ready issue handshake toward the datapath.
- Handles program start, stalls, NOP skipping, HALT, abort and end-of-memory termination.

Parameters:
ADDR_W, 8, instruction memory address width; program length is at most 2^ADDR_W words.
INSTR_W, 16, instruction word width; [INSTR_W-1:INSTR_W-3] = op_code, [INSTR_W-4:0] = operand.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins execution at address 0
abort  input  1  returns the sequencer to IDLE from any state
imem_addr  output  ADDR_W  instruction memory read address (= pc)
imem_data  input  INSTR_W  instruction memory read data; 1-cycle read latency
op_code  output  3  op_code to the control unit
operand  output  INSTR_W-3  operand field of the issued instruction
op_valid  output  1  op_code/operand hold a live instruction
op_ready  input  1  datapath accepts the instruction this cycle
busy  output  1  high in FETCH, DECODE and ISSUE
done  output  1  high in DONE
instr_count  output  ADDR_W+1  number of instructions accepted since the last start

Behaviour:
- Reset (async, rst=1): state=IDLE, pc=0, op_code=3'b010, operand=0, op_valid=0, done=0, instr_count=0.
- Reserved encodings: 3'b010 = NOP (control unit default: no writes); 3'b011 = HALT. All other codes are issued.
- op_code and operand are registered. Outside ISSUE, op_code=3'b010 and op_valid=0, so the control unit never writes spuriously.
- imem_addr = pc (combinational from the pc register).
- States:
  - IDLE: waits for start. On start: pc<=0, instr_count<=0, done<=0, go to FETCH.
  - FETCH: 1 cycle; memory samples imem_addr. Go to DECODE.
  - DECODE: imem_data is valid this cycle.
    - op=HALT: go to DONE.
    - op=NOP: if pc==2^ADDR_W-1, go to DONE; else pc<=pc+1, go to FETCH. NOP is not counted.
    - Otherwise: latch op_code and operand, set op_valid<=1, go to ISSUE.
  - ISSUE: op_valid, op_code and operand stay stable until op_ready=1. On the op_ready edge: instr_count<=instr_count+1, op_valid<=0, op_code<=3'b010.
    - If pc==2^ADDR_W-1, go to DONE (no wrap).
    - Otherwise pc<=pc+1, go to FETCH.
  - DONE: done=1, busy=0. A start pulse restarts exactly as from IDLE (done clears on the same edge).
- Minimum throughput: 3 cycles per issued instruction; each op_ready=0 cycle adds one cycle.
- start is ignored while busy=1.
- abort has priority over every other event in the same cycle, including op_ready. It forces IDLE, op_valid=0, op_code=3'b010, done=0. pc and instr_count hold until the next start.
- An op_ready that arrives while op_valid=0 is ignored.
- rst asserted mid-operation: immediate return to reset values regardless of state.

Test Plan:
- Program {0:3'b100, 1:3'b101, 2:3'b000, 3:HALT}, op_ready=1, pulse start → op_code 100,101,000 each valid exactly 1 cycle, 3 cycles apart; done=1; instr_count=3.
- Same program with op_ready held 0 for 4 cycles on the first op → op_code=100 and operand stay stable for 5 cycles; second op issues 3 cycles after acceptance; instr_count=3.
- Program {0:NOP, 1:NOP, 2:3'b111, 3:HALT} → only 111 issued, first op_valid 7 cycles after start; instr_count=1.
- ADDR_W=2, no HALT, four 3'b001 words → 4 issues, then done=1; pc never wraps to 0; instr_count=4.
- abort asserted in the same cycle as op_ready during the second issue → IDLE, op_valid=0, instr_count=1; a later start restarts at address 0 with count 0.
- rst pulsed during ISSUE → all outputs at reset values within the same cycle; start pulsed during busy → no effect.
